// File: rtl/spi_flash_emu_if.sv
`default_nettype none
// ============================================================================
//  Module      : spi_flash_emu_if
//  Description : Bundles the SPI flash pins, the backing-memory read port and
//                the command status outputs of the SPI flash emulator.
//  Revision    : 1.0 - initial release
// ============================================================================
interface spi_flash_emu_if #(
   parameter int MEM_AW = 16
) ();

   // SPI side (driven by the external SPI master)
   logic              flash_csb;
   logic              flash_clk;
   logic              flash_io0_di;
   logic              flash_io1_do;
   logic              flash_io1_oeb;

   // Backing memory read port
   logic [MEM_AW-1:0] mem_addr;
   logic              mem_rd;
   logic [7:0]        mem_rdata;

   // Command status
   logic [7:0]        last_cmd;
   logic              cmd_unsupported;

   // The emulator itself
   modport slave (
      input  flash_csb,
      input  flash_clk,
      input  flash_io0_di,
      input  mem_rdata,
      output flash_io1_do,
      output flash_io1_oeb,
      output mem_addr,
      output mem_rd,
      output last_cmd,
      output cmd_unsupported
   );

   // The environment: SPI master plus backing memory
   modport master (
      output flash_csb,
      output flash_clk,
      output flash_io0_di,
      output mem_rdata,
      input  flash_io1_do,
      input  flash_io1_oeb,
      input  mem_addr,
      input  mem_rd,
      input  last_cmd,
      input  cmd_unsupported
   );

endinterface
`default_nettype wire

// File: rtl/spi_flash_emu.sv
`default_nettype none
// ============================================================================
//  Module      : spi_flash_emu
//  Description : SPI (mode 0) serial flash emulator running entirely in the
//                core_clk domain. Supports READ (03), FAST READ (0B) and
//                READ JEDEC ID (9F); other commands are flagged and ignored.
//                Read data comes from an external byte-wide memory with a
//                one-cycle read latency.
//  Revision    : 1.0 - initial release
// ============================================================================
module spi_flash_emu #(
   parameter int          MEM_AW   = 16,
   parameter logic [23:0] JEDEC_ID = 24'hEF4016
) (
   input  logic               core_clk,
   input  logic               core_rstn,
   spi_flash_emu_if.slave     bus
);

   // Width of the input shift register: enough history to rebuild either the
   // command byte or the low MEM_AW address bits together with the bit being
   // sampled. Address bits above MEM_AW simply fall off the top.
   localparam int SHW = (MEM_AW - 1 > 7) ? (MEM_AW - 1) : 7;

   typedef enum logic [2:0] {
      S_IDLE   = 3'd0,
      S_CMD    = 3'd1,
      S_ADDR   = 3'd2,
      S_DUMMY  = 3'd3,
      S_DATA   = 3'd4,
      S_ID     = 3'd5,
      S_IGNORE = 3'd6
   } state_t;

   // ------------------------------------------------------------------------
   // Synchronisers and edge-detect history
   // ------------------------------------------------------------------------
   logic csb_meta_q, csb_sync_q, csb_prev_q;
   logic clk_meta_q, clk_sync_q, clk_prev_q;
   logic io0_meta_q, io0_sync_q;

   // Protocol state
   state_t            state_q,    state_d;
   logic [4:0]        bitcnt_q,   bitcnt_d;
   logic [2:0]        outcnt_q,   outcnt_d;
   logic [SHW-1:0]    shin_q,     shin_d;
   logic [7:0]        sout_q,     sout_d;
   logic [23:0]       id_sr_q,    id_sr_d;
   logic [MEM_AW-1:0] addr_q,     addr_d;
   logic              fast_q,     fast_d;
   logic              do_q,       do_d;
   logic              mem_rd_q,   mem_rd_d;
   logic [MEM_AW-1:0] mem_addr_q, mem_addr_d;
   logic              rd_pend_q,  rd_pend_d;
   logic [7:0]        last_cmd_q, last_cmd_d;
   logic              unsup_q,    unsup_d;

   // Edge strobes on the synchronised pins. SPI clock edges only count while
   // the synchronised chip select is low, which also makes a csb rise win
   // over a clock edge landing in the same core_clk.
   logic              w_csb_fall;
   logic              w_csb_rise;
   logic              w_clk_rise;
   logic              w_clk_fall;
   logic [7:0]        w_cmd;
   logic [MEM_AW-1:0] w_addr;

   assign w_csb_fall = csb_prev_q & ~csb_sync_q;
   assign w_csb_rise = ~csb_prev_q & csb_sync_q;
   assign w_clk_rise = ~clk_prev_q & clk_sync_q & ~csb_sync_q;
   assign w_clk_fall = clk_prev_q & ~clk_sync_q & ~csb_sync_q;

   // Byte/address as they will look once the bit sampled this cycle is in
   assign w_cmd  = {shin_q[6:0], io0_sync_q};
   assign w_addr = {shin_q[MEM_AW-2:0], io0_sync_q};

   // Two-flop synchronisers plus one history flop for csb/clk edge detection
   always_ff @(posedge core_clk or negedge core_rstn) begin
      if (!core_rstn) begin
         csb_meta_q <= 1'b1;
         csb_sync_q <= 1'b1;
         csb_prev_q <= 1'b1;
         clk_meta_q <= 1'b0;
         clk_sync_q <= 1'b0;
         clk_prev_q <= 1'b0;
         io0_meta_q <= 1'b0;
         io0_sync_q <= 1'b0;
      end else begin
         csb_meta_q <= bus.flash_csb;
         csb_sync_q <= csb_meta_q;
         csb_prev_q <= csb_sync_q;
         clk_meta_q <= bus.flash_clk;
         clk_sync_q <= clk_meta_q;
         clk_prev_q <= clk_sync_q;
         io0_meta_q <= bus.flash_io0_di;
         io0_sync_q <= io0_meta_q;
      end
   end

   // State and datapath registers
   always_ff @(posedge core_clk or negedge core_rstn) begin
      if (!core_rstn) begin
         state_q    <= S_IDLE;
         bitcnt_q   <= 5'd0;
         outcnt_q   <= 3'd0;
         shin_q     <= '0;
         sout_q     <= 8'h00;
         id_sr_q    <= 24'h000000;
         addr_q     <= '0;
         fast_q     <= 1'b0;
         do_q       <= 1'b0;
         mem_rd_q   <= 1'b0;
         mem_addr_q <= '0;
         rd_pend_q  <= 1'b0;
         last_cmd_q <= 8'h00;
         unsup_q    <= 1'b0;
      end else begin
         state_q    <= state_d;
         bitcnt_q   <= bitcnt_d;
         outcnt_q   <= outcnt_d;
         shin_q     <= shin_d;
         sout_q     <= sout_d;
         id_sr_q    <= id_sr_d;
         addr_q     <= addr_d;
         fast_q     <= fast_d;
         do_q       <= do_d;
         mem_rd_q   <= mem_rd_d;
         mem_addr_q <= mem_addr_d;
         rd_pend_q  <= rd_pend_d;
         last_cmd_q <= last_cmd_d;
         unsup_q    <= unsup_d;
      end
   end

   // Next-state and datapath logic for the command/address/data sequencer
   always_comb begin
      state_d    = state_q;
      bitcnt_d   = bitcnt_q;
      outcnt_d   = outcnt_q;
      shin_d     = shin_q;
      sout_d     = sout_q;
      id_sr_d    = id_sr_q;
      addr_d     = addr_q;
      fast_d     = fast_q;
      do_d       = do_q;
      mem_rd_d   = 1'b0;
      mem_addr_d = mem_addr_q;
      rd_pend_d  = mem_rd_q;
      last_cmd_d = last_cmd_q;
      unsup_d    = 1'b0;

      // Read data is valid the cycle after the strobe; it lands in the output
      // shift register well before the next SPI falling edge can use it.
      if (rd_pend_q) begin
         sout_d = bus.mem_rdata;
      end

      if (w_csb_rise) begin
         state_d  = S_IDLE;
         bitcnt_d = 5'd0;
         outcnt_d = 3'd0;
         fast_d   = 1'b0;
         do_d     = 1'b0;
      end else if (w_csb_fall) begin
         state_d  = S_CMD;
         bitcnt_d = 5'd0;
         outcnt_d = 3'd0;
         fast_d   = 1'b0;
         do_d     = 1'b0;
      end else begin
         case (state_q)
            S_CMD: begin
               if (w_clk_rise) begin
                  shin_d   = {shin_q[SHW-2:0], io0_sync_q};
                  bitcnt_d = bitcnt_q + 5'd1;
                  if (bitcnt_q == 5'd7) begin
                     bitcnt_d   = 5'd0;
                     last_cmd_d = w_cmd;
                     case (w_cmd)
                        8'h03: state_d = S_ADDR;
                        8'h0B: begin
                           state_d = S_ADDR;
                           fast_d  = 1'b1;
                        end
                        8'h9F: begin
                           state_d = S_ID;
                           id_sr_d = JEDEC_ID;
                        end
                        default: begin
                           state_d = S_IGNORE;
                           unsup_d = 1'b1;
                        end
                     endcase
                  end
               end
            end

            S_ADDR: begin
               if (w_clk_rise) begin
                  shin_d   = {shin_q[SHW-2:0], io0_sync_q};
                  bitcnt_d = bitcnt_q + 5'd1;
                  if (bitcnt_q == 5'd23) begin
                     bitcnt_d   = 5'd0;
                     outcnt_d   = 3'd0;
                     addr_d     = w_addr;
                     mem_addr_d = w_addr;
                     mem_rd_d   = 1'b1;
                     state_d    = fast_q ? S_DUMMY : S_DATA;
                  end
               end
            end

            S_DUMMY: begin
               if (w_clk_rise) begin
                  bitcnt_d = bitcnt_q + 5'd1;
                  if (bitcnt_q == 5'd7) begin
                     bitcnt_d = 5'd0;
                     state_d  = S_DATA;
                  end
               end
            end

            S_DATA: begin
               if (w_clk_fall) begin
                  do_d     = sout_q[7];
                  sout_d   = {sout_q[6:0], 1'b0};
                  outcnt_d = outcnt_q + 3'd1;
                  // Bit 0 is going out now: prefetch the following byte,
                  // wrapping naturally at the top of the address space.
                  if (outcnt_q == 3'd7) begin
                     addr_d     = addr_q + 1'b1;
                     mem_addr_d = addr_q + 1'b1;
                     mem_rd_d   = 1'b1;
                  end
               end
            end

            S_ID: begin
               // Zeros shift in behind the ID, so the tail of the
               // transaction reads as 0.
               if (w_clk_fall) begin
                  do_d    = id_sr_q[23];
                  id_sr_d = {id_sr_q[22:0], 1'b0};
               end
            end

            default: ;
         endcase
      end
   end

   assign bus.flash_io1_do    = do_q;
   assign bus.flash_io1_oeb   = ~((state_q == S_DATA) | (state_q == S_ID));
   assign bus.mem_addr        = mem_addr_q;
   assign bus.mem_rd          = mem_rd_q;
   assign bus.last_cmd        = last_cmd_q;
   assign bus.cmd_unsupported = unsup_q;

endmodule
`default_nettype wire

// File: tb/tb_spi_flash_emu.sv
`default_nettype none
// ============================================================================
//  Module      : tb_spi_flash_emu
//  Description : Directed self-checking bench for spi_flash_emu. Acts as the
//                SPI master (mode 0, 16 core_clk per SPI bit) and as the
//                backing memory.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_spi_flash_emu;

   logic core_clk = 1'b0;
   logic core_rstn;

   int n_tests     = 0;
   int n_fail      = 0;
   int rd_total    = 0;
   int unsup_total = 0;
   logic        oeb_low_seen;
   logic [15:0] rd_log [0:255];
   logic [7:0]  mem    [0:65535];

   spi_flash_emu_if #(.MEM_AW(16)) bus ();

   spi_flash_emu #(
      .MEM_AW   (16),
      .JEDEC_ID (24'hEF4016)
   ) dut (
      .core_clk  (core_clk),
      .core_rstn (core_rstn),
      .bus       (bus)
   );

   always #5 core_clk = ~core_clk;

   // Backing memory with one-cycle read latency
   always @(posedge core_clk) begin
      if (bus.mem_rd) bus.mem_rdata <= mem[bus.mem_addr];
   end

   // Log every read strobe and every unsupported-command pulse
   always @(posedge core_clk) begin
      if (bus.mem_rd) begin
         rd_log[rd_total[7:0]] <= bus.mem_addr;
         rd_total <= rd_total + 1;
      end
      if (bus.cmd_unsupported) unsup_total <= unsup_total + 1;
   end

   // One SPI bit: falling edge + MOSI, sample MISO late in the low phase,
   // then the rising edge.
   task automatic spi_bit(input logic b, output logic miso);
      bus.flash_clk    = 1'b0;
      bus.flash_io0_di = b;
      repeat (8) @(negedge core_clk);
      miso = bus.flash_io1_do;
      if (bus.flash_io1_oeb === 1'b0) oeb_low_seen = 1'b1;
      bus.flash_clk = 1'b1;
      repeat (8) @(negedge core_clk);
   endtask

   task automatic spi_byte(input logic [7:0] tx, output logic [7:0] rx);
      logic m;
      for (int i = 7; i >= 0; i--) begin
         spi_bit(tx[i], m);
         rx[i] = m;
      end
   endtask

   task automatic cs_start();
      bus.flash_csb = 1'b0;
      repeat (8) @(negedge core_clk);
   endtask

   task automatic cs_end();
      bus.flash_clk = 1'b0;
      repeat (8) @(negedge core_clk);
      bus.flash_csb = 1'b1;
      repeat (8) @(negedge core_clk);
   endtask

   task automatic send_read_hdr(input logic [7:0] cmd, input logic [23:0] a);
      logic [7:0] rx;
      spi_byte(cmd, rx);
      spi_byte(a[23:16], rx);
      spi_byte(a[15:8], rx);
      spi_byte(a[7:0], rx);
   endtask

   task automatic test_reset();
      repeat (3) @(negedge core_clk);
      n_tests++; if (bus.flash_io1_do !== 1'b0) begin n_fail++; $display("FAIL reset_do: got %b expected 0", bus.flash_io1_do); end
      n_tests++; if (bus.flash_io1_oeb !== 1'b1) begin n_fail++; $display("FAIL reset_oeb: got %b expected 1", bus.flash_io1_oeb); end
      n_tests++; if (bus.mem_rd !== 1'b0) begin n_fail++; $display("FAIL reset_mem_rd: got %b expected 0", bus.mem_rd); end
      n_tests++; if (bus.mem_addr !== 16'h0000) begin n_fail++; $display("FAIL reset_mem_addr: got %h expected 0000", bus.mem_addr); end
      n_tests++; if (bus.last_cmd !== 8'h00) begin n_fail++; $display("FAIL reset_last_cmd: got %h expected 00", bus.last_cmd); end
      n_tests++; if (bus.cmd_unsupported !== 1'b0) begin n_fail++; $display("FAIL reset_unsup: got %b expected 0", bus.cmd_unsupported); end
      core_rstn = 1'b1;
      repeat (4) @(negedge core_clk);
   endtask

   task automatic test_read();
      logic [7:0] b0, b1;
      int base;
      base = rd_total;
      cs_start();
      send_read_hdr(8'h03, 24'h000010);
      spi_byte(8'h00, b0);
      spi_byte(8'h00, b1);
      n_tests++; if (bus.flash_io1_oeb !== 1'b0) begin n_fail++; $display("FAIL read_oeb_data: got %b expected 0", bus.flash_io1_oeb); end
      cs_end();
      n_tests++; if (b0 !== 8'hA5) begin n_fail++; $display("FAIL read_byte0: got %h expected A5", b0); end
      n_tests++; if (b1 !== 8'h3C) begin n_fail++; $display("FAIL read_byte1: got %h expected 3C", b1); end
      n_tests++; if (bus.last_cmd !== 8'h03) begin n_fail++; $display("FAIL read_last_cmd: got %h expected 03", bus.last_cmd); end
      n_tests++; if (rd_total - base < 2) begin n_fail++; $display("FAIL read_rd_count: got %0d expected >=2", rd_total - base); end
      n_tests++; if (rd_log[base] !== 16'h0010) begin n_fail++; $display("FAIL read_rd_addr0: got %h expected 0010", rd_log[base]); end
      n_tests++; if (rd_log[base+1] !== 16'h0011) begin n_fail++; $display("FAIL read_rd_addr1: got %h expected 0011", rd_log[base+1]); end
      n_tests++; if (bus.flash_io1_oeb !== 1'b1) begin n_fail++; $display("FAIL read_oeb_after_cs: got %b expected 1", bus.flash_io1_oeb); end
      n_tests++; if (bus.flash_io1_do !== 1'b0) begin n_fail++; $display("FAIL read_do_after_cs: got %b expected 0", bus.flash_io1_do); end
   endtask

   task automatic test_fast_read_wrap();
      logic [7:0] b0, b1, d;
      int base;
      base = rd_total;
      cs_start();
      send_read_hdr(8'h0B, 24'h00FFFF);
      oeb_low_seen = 1'b0;
      spi_byte(8'h00, d);
      n_tests++; if (oeb_low_seen !== 1'b0) begin n_fail++; $display("FAIL fast_oeb_dummy: got low expected high"); end
      spi_byte(8'h00, b0);
      spi_byte(8'h00, b1);
      cs_end();
      n_tests++; if (b0 !== 8'h5A) begin n_fail++; $display("FAIL fast_byte_ffff: got %h expected 5A", b0); end
      n_tests++; if (b1 !== 8'hC3) begin n_fail++; $display("FAIL fast_byte_0000: got %h expected C3", b1); end
      n_tests++; if (rd_log[base] !== 16'hFFFF) begin n_fail++; $display("FAIL fast_rd_addr0: got %h expected FFFF", rd_log[base]); end
      n_tests++; if (rd_log[base+1] !== 16'h0000) begin n_fail++; $display("FAIL fast_rd_addr1: got %h expected 0000", rd_log[base+1]); end
      n_tests++; if (bus.last_cmd !== 8'h0B) begin n_fail++; $display("FAIL fast_last_cmd: got %h expected 0B", bus.last_cmd); end
   endtask

   task automatic test_jedec_id();
      logic [7:0] rx, id0, id1, id2, id3;
      int base;
      base = rd_total;
      cs_start();
      spi_byte(8'h9F, rx);
      spi_byte(8'h00, id0);
      spi_byte(8'h00, id1);
      spi_byte(8'h00, id2);
      spi_byte(8'h00, id3);
      cs_end();
      n_tests++; if ({id0, id1, id2, id3} !== 32'hEF401600) begin n_fail++; $display("FAIL jedec_id: got %h expected EF401600", {id0, id1, id2, id3}); end
      n_tests++; if (bus.last_cmd !== 8'h9F) begin n_fail++; $display("FAIL jedec_last_cmd: got %h expected 9F", bus.last_cmd); end
      n_tests++; if (rd_total != base) begin n_fail++; $display("FAIL jedec_no_rd: got %0d reads expected 0", rd_total - base); end
   endtask

   task automatic test_unsupported();
      logic [7:0] rx;
      int base_r, base_u;
      base_r = rd_total;
      base_u = unsup_total;
      oeb_low_seen = 1'b0;
      cs_start();
      spi_byte(8'h06, rx);
      spi_byte(8'hFF, rx);
      spi_byte(8'hFF, rx);
      cs_end();
      n_tests++; if (unsup_total - base_u != 1) begin n_fail++; $display("FAIL unsup_pulses: got %0d expected 1", unsup_total - base_u); end
      n_tests++; if (oeb_low_seen !== 1'b0) begin n_fail++; $display("FAIL unsup_oeb: got low expected high"); end
      n_tests++; if (bus.last_cmd !== 8'h06) begin n_fail++; $display("FAIL unsup_last_cmd: got %h expected 06", bus.last_cmd); end
      n_tests++; if (rd_total != base_r) begin n_fail++; $display("FAIL unsup_no_rd: got %0d reads expected 0", rd_total - base_r); end
   endtask

   task automatic test_abort();
      logic [7:0] rx, b0;
      logic m;
      int base;
      base = rd_total;
      cs_start();
      spi_byte(8'h03, rx);
      spi_byte(8'h00, rx);
      for (int i = 0; i < 4; i++) spi_bit(1'b0, m);
      cs_end();
      n_tests++; if (rd_total != base) begin n_fail++; $display("FAIL abort_no_rd: got %0d reads expected 0", rd_total - base); end
      cs_start();
      send_read_hdr(8'h03, 24'h000010);
      spi_byte(8'h00, b0);
      cs_end();
      n_tests++; if (b0 !== 8'hA5) begin n_fail++; $display("FAIL abort_reread: got %h expected A5", b0); end
      n_tests++; if (rd_log[base] !== 16'h0010) begin n_fail++; $display("FAIL abort_rd_addr: got %h expected 0010", rd_log[base]); end
   endtask

   task automatic test_reset_mid_data();
      logic [7:0] rx, b0, b1;
      logic m;
      cs_start();
      send_read_hdr(8'h03, 24'h000010);
      spi_byte(8'h00, rx);
      // Three bits of 3C: 0,0,1 -- MISO is left driving 1
      for (int i = 0; i < 3; i++) spi_bit(1'b0, m);
      n_tests++; if (m !== 1'b1) begin n_fail++; $display("FAIL rst_pre_do: got %b expected 1", m); end
      #2;
      core_rstn = 1'b0;
      #1;
      n_tests++; if (bus.flash_io1_oeb !== 1'b1) begin n_fail++; $display("FAIL rst_mid_oeb: got %b expected 1", bus.flash_io1_oeb); end
      n_tests++; if (bus.flash_io1_do !== 1'b0) begin n_fail++; $display("FAIL rst_mid_do: got %b expected 0", bus.flash_io1_do); end
      n_tests++; if (bus.last_cmd !== 8'h00) begin n_fail++; $display("FAIL rst_mid_last_cmd: got %h expected 00", bus.last_cmd); end
      bus.flash_clk = 1'b0;
      bus.flash_csb = 1'b1;
      repeat (4) @(negedge core_clk);
      core_rstn = 1'b1;
      repeat (8) @(negedge core_clk);
      cs_start();
      send_read_hdr(8'h03, 24'h000010);
      spi_byte(8'h00, b0);
      spi_byte(8'h00, b1);
      cs_end();
      n_tests++; if (b0 !== 8'hA5) begin n_fail++; $display("FAIL rst_after_byte0: got %h expected A5", b0); end
      n_tests++; if (b1 !== 8'h3C) begin n_fail++; $display("FAIL rst_after_byte1: got %h expected 3C", b1); end
   endtask

   initial begin
      core_rstn        = 1'b0;
      bus.flash_csb    = 1'b1;
      bus.flash_clk    = 1'b0;
      bus.flash_io0_di = 1'b0;
      oeb_low_seen     = 1'b0;
      for (int i = 0; i < 65536; i++) mem[i] = 8'h00;
      mem[16'h0010] = 8'hA5;
      mem[16'h0011] = 8'h3C;
      mem[16'h0012] = 8'h77;
      mem[16'hFFFF] = 8'h5A;
      mem[16'h0000] = 8'hC3;

      test_reset();
      test_read();
      test_fast_read_wrap();
      test_jedec_id();
      test_unsupported();
      test_abort();
      test_reset_mid_data();

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
`default_nettype wire

// File: doc/spi_flash_emu.md
SPI_FLASH_EMU -- requirements
Module: spi_flash_emu

Interface
REQ-001 Parameter MEM_AW, default 16, sets the byte-address width of the backing memory port.
REQ-002 Parameter JEDEC_ID, default 24'hEF4016, is the value returned by command 0x9F.
REQ-003 core_clk  in  1  sole clock; all state updates on its rising edge.
REQ-004 core_rstn  in  1  reset, asynchronous assert, active-low.
REQ-005 flash_csb  in  1  chip select from the SPI master, active-low, asynchronous to core_clk.
REQ-006 flash_clk  in  1  SPI clock from the master (mode 0), asynchronous to core_clk.
REQ-007 flash_io0_di  in  1  serial data from the master (MOSI).
REQ-008 flash_io1_do  out  1  serial data to the master (MISO).
REQ-009 flash_io1_oeb  out  1  output enable for io1, active-low; 1 means tri-state.
REQ-010 mem_addr  out  MEM_AW  byte address to the backing memory.
REQ-011 mem_rd  out  1  one-core_clk read strobe.
REQ-012 mem_rdata  in  8  read data, valid exactly 1 core_clk after mem_rd.
REQ-013 last_cmd  out  8  most recently received command byte.
REQ-014 cmd_unsupported  out  1  one-core_clk pulse on an unrecognised command.

Function
REQ-015 flash_csb, flash_clk and flash_io0_di SHALL each pass through a 2-flop synchroniser; edges are detected on the synchronised values.
REQ-016 The block SHALL operate correctly when the flash_clk period is at least 8 core_clk periods; faster flash_clk is unsupported.
REQ-017 States: IDLE, CMD, ADDR, DUMMY, DATA, ID, IGNORE.
REQ-018 A synchronised csb falling edge SHALL enter CMD with the bit counter at 0.
REQ-019 A synchronised csb rising edge in any state SHALL enter IDLE, set oeb=1 and do=0, and clear counters; no mem_rd is issued.
REQ-020 While csb is low, each flash_clk rising edge SHALL shift io0 into the input shift register, MSB first.
REQ-021 After 8 bits in CMD, last_cmd SHALL be updated and the next state chosen: 0x03 to ADDR, 0x0B to ADDR with the fast flag set, 0x9F to ID, any other value to IGNORE with a cmd_unsupported pulse.
REQ-022 ADDR SHALL collect 24 bits, of which the low MEM_AW bits form the address and the upper bits are ignored.
REQ-023 On the 24th address bit, mem_rd SHALL pulse with mem_addr equal to the address, and mem_rdata SHALL be loaded into the output shift register on the next core_clk.
REQ-024 After the address, a fast read SHALL enter DUMMY and count 8 rising edges before entering DATA; a plain read SHALL enter DATA directly.
REQ-025 In DATA, each flash_clk falling edge SHALL drive the next output bit on io1, MSB first; the first falling edge after the last address or dummy rising edge drives bit 7.
REQ-026 On the falling edge that drives bit 0, mem_rd SHALL pulse for address+1; the returned byte is loaded so that the next falling edge drives its bit 7.
REQ-027 The address SHALL wrap from 2^MEM_AW-1 to 0.
REQ-028 In ID, io1 SHALL shift JEDEC_ID MSB first on falling edges, then drive 0 for the remainder of the transaction.
REQ-029 flash_io1_oeb SHALL be 0 only in DATA and ID; IGNORE SHALL discard all bits until csb rises.
REQ-030 A simultaneous csb rise and clk edge in the same core_clk SHALL be handled as the csb rise only.

Reset
REQ-031 While core_rstn is low, the outputs SHALL be: flash_io1_do=0, flash_io1_oeb=1, mem_rd=0, mem_addr=0, last_cmd=8'h00, cmd_unsupported=0, state=IDLE.
REQ-032 The synchroniser reset values SHALL be csb=1 and clk=0.
REQ-033 Reset SHALL take effect immediately at any point, including mid-transaction; after release, the block waits for a fresh csb falling edge.

Verification
REQ-034 Memory 0x0010=A5, 0x0011=3C; send READ 03 00 00 10 and clock 16 bits -> MISO returns A5 then 3C; mem_rd pulses with mem_addr 0x0010 then 0x0011.
REQ-035 Send FAST READ 0B 00 FF FF, then 8 dummy bits, then clock 16 bits -> returns bytes at 0xFFFF then 0x0000 (wrap); oeb=1 during the dummy bits.
REQ-036 Send 9F and clock 32 bits -> returns EF 40 16 00; last_cmd=9F.
REQ-037 Send 06 and clock 16 more bits -> one cmd_unsupported pulse, oeb stays 1, last_cmd=06, no mem_rd.
REQ-038 Raise csb after 12 address bits, then issue a full READ at 0x0010 -> no mem_rd from the aborted transaction, and the second read returns A5.
REQ-039 Assert core_rstn low mid-DATA -> oeb=1 and do=0 immediately; a READ after reset release behaves as in REQ-034.
